// File: rtl/axil_cmd_master.sv
// axil_cmd_master: single-outstanding AXI4-Lite master.
// Turns one register command at a time into an AXI4-Lite read or write,
// returns the data/response on a valid/ready port and keeps saturating
// statistics of completed writes, reads and error responses.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a command; cmd_ready is high only here
// WR    | AW and W presented, each held until its own handshake
// WR_B  | both write handshakes done, bready high, waiting for B
// RD_A  | AR presented, waiting for arready
// RD_R  | rready high, waiting for R
// RSP   | response held on rsp_* until rsp_ready
module axil_cmd_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_CNT_WIDTH        = 16
) (
  input  logic                            m00_axi_aclk,
  input  logic                            m00_axi_areset,
  // command port
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [31:0]                     cmd_wdata,
  input  logic [3:0]                      cmd_wstrb,
  // response port
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [31:0]                     rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_write,
  // write address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m00_axi_awaddr,
  output logic [2:0]                      m00_axi_awprot,
  output logic                            m00_axi_awvalid,
  input  logic                            m00_axi_awready,
  // write data channel
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m00_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m00_axi_wstrb,
  output logic                            m00_axi_wvalid,
  input  logic                            m00_axi_wready,
  // write response channel
  input  logic [1:0]                      m00_axi_bresp,
  input  logic                            m00_axi_bvalid,
  output logic                            m00_axi_bready,
  // read address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m00_axi_araddr,
  output logic [2:0]                      m00_axi_arprot,
  output logic                            m00_axi_arvalid,
  input  logic                            m00_axi_arready,
  // read data channel
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m00_axi_rdata,
  input  logic [1:0]                      m00_axi_rresp,
  input  logic                            m00_axi_rvalid,
  output logic                            m00_axi_rready,
  // statistics
  output logic [C_CNT_WIDTH-1:0]          wr_count,
  output logic [C_CNT_WIDTH-1:0]          rd_count,
  output logic [C_CNT_WIDTH-1:0]          err_count
);

  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_R, RSP} state_t;

  state_t state_q, state_d;

  logic                            aw_done_q, aw_done_d;
  logic                            w_done_q,  w_done_d;
  logic                            awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_d, araddr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_d;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_d;
  logic                            rsp_valid_d, rsp_write_d;
  logic [31:0]                     rsp_rdata_d;
  logic [1:0]                      rsp_resp_d;
  logic [C_CNT_WIDTH-1:0]          wr_count_d, rd_count_d, err_count_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign aw_hs = m00_axi_awvalid & m00_axi_awready;
  assign w_hs  = m00_axi_wvalid  & m00_axi_wready;
  assign b_hs  = m00_axi_bvalid  & m00_axi_bready;
  assign ar_hs = m00_axi_arvalid & m00_axi_arready;
  assign r_hs  = m00_axi_rvalid  & m00_axi_rready;

  // Accepting only in IDLE keeps commands and responses from overlapping.
  assign cmd_ready      = (state_q == IDLE);
  assign m00_axi_awprot = 3'b000;
  assign m00_axi_arprot = 3'b000;

  function automatic logic [C_CNT_WIDTH-1:0] sat_inc(input logic [C_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + C_CNT_WIDTH'(1);
  endfunction

  // Next-state and next-output decode; every registered output has a hold default.
  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    awvalid_d   = m00_axi_awvalid;
    wvalid_d    = m00_axi_wvalid;
    bready_d    = m00_axi_bready;
    arvalid_d   = m00_axi_arvalid;
    rready_d    = m00_axi_rready;
    awaddr_d    = m00_axi_awaddr;
    araddr_d    = m00_axi_araddr;
    wdata_d     = m00_axi_wdata;
    wstrb_d     = m00_axi_wstrb;
    rsp_valid_d = rsp_valid;
    rsp_write_d = rsp_write;
    rsp_rdata_d = rsp_rdata;
    rsp_resp_d  = rsp_resp;
    wr_count_d  = wr_count;
    rd_count_d  = rd_count;
    err_count_d = err_count;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = WR;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = RD_A;
          end
        end
      end

      WR: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        // The current-cycle handshake counts so a same-cycle AW/W pair moves on at once.
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          bready_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_B;
        end
      end

      WR_B: begin
        if (b_hs) begin
          bready_d    = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_resp_d  = m00_axi_bresp;
          rsp_write_d = 1'b1;
          rsp_valid_d = 1'b1;
          wr_count_d  = sat_inc(wr_count);
          if (m00_axi_bresp != 2'b00) err_count_d = sat_inc(err_count);
          state_d     = RSP;
        end
      end

      RD_A: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_R;
        end
      end

      RD_R: begin
        if (r_hs) begin
          rready_d    = 1'b0;
          rsp_rdata_d = m00_axi_rdata;
          rsp_resp_d  = m00_axi_rresp;
          rsp_write_d = 1'b0;
          rsp_valid_d = 1'b1;
          rd_count_d  = sat_inc(rd_count);
          if (m00_axi_rresp != 2'b00) err_count_d = sat_inc(err_count);
          state_d     = RSP;
        end
      end

      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge m00_axi_aclk) begin
    if (m00_axi_areset) begin
      state_q         <= IDLE;
      aw_done_q       <= 1'b0;
      w_done_q        <= 1'b0;
      m00_axi_awvalid <= 1'b0;
      m00_axi_wvalid  <= 1'b0;
      m00_axi_bready  <= 1'b0;
      m00_axi_arvalid <= 1'b0;
      m00_axi_rready  <= 1'b0;
      m00_axi_awaddr  <= '0;
      m00_axi_araddr  <= '0;
      m00_axi_wdata   <= '0;
      m00_axi_wstrb   <= '0;
      rsp_valid       <= 1'b0;
      rsp_write       <= 1'b0;
      rsp_rdata       <= 32'h0;
      rsp_resp        <= 2'b00;
      wr_count        <= '0;
      rd_count        <= '0;
      err_count       <= '0;
    end else begin
      state_q         <= state_d;
      aw_done_q       <= aw_done_d;
      w_done_q        <= w_done_d;
      m00_axi_awvalid <= awvalid_d;
      m00_axi_wvalid  <= wvalid_d;
      m00_axi_bready  <= bready_d;
      m00_axi_arvalid <= arvalid_d;
      m00_axi_rready  <= rready_d;
      m00_axi_awaddr  <= awaddr_d;
      m00_axi_araddr  <= araddr_d;
      m00_axi_wdata   <= wdata_d;
      m00_axi_wstrb   <= wstrb_d;
      rsp_valid       <= rsp_valid_d;
      rsp_write       <= rsp_write_d;
      rsp_rdata       <= rsp_rdata_d;
      rsp_resp        <= rsp_resp_d;
      wr_count        <= wr_count_d;
      rd_count        <= rd_count_d;
      err_count       <= err_count_d;
    end
  end

endmodule

// File: doc/axil_cmd_master.md
Name: axil_cmd_master

Overview:
- Single-outstanding AXI4-Lite master that sits directly upstream of the Decoder register slave (S00_AXI) and replaces the simulation BFM in hardware.
- Accepts simple register commands (read or write, address, data, strobe) on a valid/ready port and runs the matching AXI4-Lite transaction.
- Returns read data and the response code on a valid/ready response port.
- Keeps saturating counters of completed writes, completed reads and error responses.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, AXI address width.
- C_M_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_CNT_WIDTH, 16, width of each statistics counter.

Ports:
- m00_axi_aclk  in  1  clock.
- m00_axi_areset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  C_M_AXI_ADDR_WIDTH  target byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write byte strobes.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP of the transaction.
- rsp_write  out  1  echoes cmd_write of the transaction.
- m00_axi_awaddr / awprot / awvalid  out  ADDR / 3 / 1  write address channel.
- m00_axi_awready  in  1.
- m00_axi_wdata / wstrb / wvalid  out  32 / 4 / 1  write data channel.
- m00_axi_wready  in  1.
- m00_axi_bresp  in  2.
- m00_axi_bvalid  in  1.
- m00_axi_bready  out  1.
- m00_axi_araddr / arprot / arvalid  out  ADDR / 3 / 1  read address channel.
- m00_axi_arready  in  1.
- m00_axi_rdata  in  32.
- m00_axi_rresp  in  2.
- m00_axi_rvalid  in  1.
- m00_axi_rready  out  1.
- wr_count, rd_count, err_count  out  C_CNT_WIDTH each  statistics counters.

Behaviour:
- All outputs are registered except cmd_ready, which is (state==IDLE).
- Reset values:
  - all valid and ready outputs 0;
  - addresses, data, rsp_rdata, rsp_resp and counters 0;
  - wstrb 0; awprot and arprot 0;
  - state IDLE.
- awprot and arprot are always 3'b000.
- FSM states: IDLE, WR, WR_B, RD_A, RD_R, RSP.
- IDLE:
  - On cmd_valid, the command is captured.
  - If write: awvalid=1, wvalid=1, go to WR.
  - If read: arvalid=1, go to RD_A.
  - First AXI valid rises on the cycle after acceptance.
- WR:
  - awvalid drops on the cycle after an awvalid&awready handshake; wvalid drops independently on the cycle after wvalid&wready.
  - AW and W are held until their own handshake, in any order, including the same cycle.
  - When both handshakes are done (tracked by aw_done and w_done flags), assert bready and go to WR_B.
  - bready is never asserted before both handshakes complete.
- WR_B: on bvalid&bready, latch bresp, set rsp_rdata=0 and rsp_write=1, deassert bready, set rsp_valid, go to RSP.
- RD_A: arvalid is held until arready; then arvalid=0, rready=1, go to RD_R.
- RD_R: on rvalid&rready, latch rdata and rresp, set rsp_write=0, rready=0, rsp_valid=1, go to RSP.
- RSP:
  - rsp_valid and all rsp_* are held stable until rsp_ready; then rsp_valid=0 and go to IDLE.
  - cmd_ready becomes 1 on the following cycle, so there is no command/response overlap.
- Minimum latency with a zero-wait slave and rsp_ready held high:
  - write: cmd accept to rsp_valid = 4 cycles (accept, AW/W handshake, B handshake, rsp).
  - read: 4 cycles (accept, AR handshake, R handshake, rsp).
- Counters:
  - Update on the cycle the B or R handshake completes: wr_count += 1 on B, rd_count += 1 on R.
  - err_count += 1 when the latched resp != 2'b00.
  - All counters saturate at all-ones; there is no wrap.
- Captured command fields are stable for the whole transaction; cmd_* changes after acceptance are ignored.
- Reset mid-transaction: on the next edge every valid/ready output is 0 and state is IDLE. The transaction is abandoned and counters clear. The slave shares the same system reset.
- Only one transaction is ever outstanding. No AW/AR interleaving.

Test Plan:
- Zero-wait slave: write 0x0101FFFF, strb 0xF, to 0x00000000 -> awvalid and wvalid each high exactly 1 cycle; rsp_valid 4 cycles after acceptance; rsp_resp=00, rsp_write=1, rsp_rdata=0, wr_count=1.
- Read 0x00000000 after that write -> araddr=0x0; rsp_rdata=0x0101FFFF, rsp_resp=00, rd_count=1.
- Skewed handshake: write 0xABCD0001 to 0x4 with wready 3 cycles late and awready immediate -> awvalid drops after 1 cycle, wvalid stays until wready; bready rises only after the W handshake; read-back returns 0xABCD0001.
- Back-pressure: complete a read with rsp_ready low for 5 cycles -> rsp_valid and rsp_rdata stay stable; cmd_ready stays 0 until 1 cycle after rsp_ready.
- Error response: slave returns bresp=2'b10 on a write to 0x8 -> rsp_resp=10, err_count=1, wr_count increments.
- Reset while in WR_B with bvalid low -> next cycle all AXI valids and readies are 0, counters are 0, cmd_ready=1; a following write of 0xBEEF0011 to 0xC completes normally.
